perceptron_trainable: RTL and testbench
=======================================

// Module: perceptron_trainable
// PURPOSE
//  Parametrised, trainable perceptron. Replaces the fixed inference-only classifier.
//  Accepts a vector of N_INPUTS signed features through a valid/ready handshake.
//  Computes dot(w,x)+bias with one sequential multiply-accumulate per cycle, then classifies.
//  In train mode it also applies the perceptron learning rule with saturating weights.
//  Sits between the pin-level top wrapper (feature/target staging) and uo_out.
// PARAMETERS
//  N_INPUTS  4  number of features/weights (>=2)
//  IN_W      8  signed feature width
//  W_W       8  signed weight and bias width
//  LR_SHIFT  0  learning rate: update step = x_i >>> LR_SHIFT (arithmetic shift)
//  BIAS_STEP 1  bias update magnitude
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               asynchronous reset, active-high
//  in_valid   in   1               feature vector + mode valid
//  in_ready   out  1               core idle, can accept
//  in_data    in   N_INPUTS*IN_W   feature i = in_data[i*IN_W +: IN_W], signed
//  train_en   in   1               sampled with in_data: 1 = infer and update
//  target     in   1               desired class, sampled with in_data
//  out_valid  out  1               result available
//  out_ready  in   1               consumer takes result
//  out_class  out  1               1 when acc >= 0
//  out_acc    out  ACC_W           signed dot product + bias
//  out_upd    out  1               1 = weights were changed by this transaction
//  w_wr_en    in   1               preload strobe, honoured only in IDLE
//  w_wr_idx   in   clog2(N+1)      0..N-1 = weight i, N = bias
//  w_wr_data  in   W_W             preload value
//  w_rd_idx   in   clog2(N+1)      combinational readback select
//  w_rd_data  out  W_W             weight/bias at w_rd_idx; 0 if idx > N
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-high.
//  - Reset values: weights=0, bias=0, state=IDLE, in_ready=1, out_valid=0, out_class=0,
//    out_acc=0, out_upd=0.
//  - ACC_W = IN_W+W_W+clog2(N_INPUTS)+1. Accumulation is exact (no overflow possible).
//  - FSM IDLE -> MAC -> DECIDE -> [UPDATE] -> OUT -> IDLE.
//  - IDLE: in_ready=1.
//    - in_valid&in_ready at edge T latches in_data, train_en, target; acc <= sign-extended bias.
//    - A w_wr_en in the same cycle as acceptance is applied before the transaction;
//      the bias, if written, is loaded into acc.
//  - MAC: N_INPUTS cycles, index 0..N-1. acc += w_i*x_i (signed).
//  - DECIDE: 1 cycle. cls = (acc >= 0). err = train_en & (cls != target).
//    - err=1 -> go to UPDATE.
//    - err=0 -> go to OUT.
//  - UPDATE: N_INPUTS cycles, one weight per cycle, then 1 more cycle updates the bias (next: OUT).
//    - Step s_i = x_i >>> LR_SHIFT.
//    - target=1: w_i += s_i, bias += BIAS_STEP.
//    - target=0: w_i -= s_i, bias -= BIAS_STEP.
//    - Each result saturates to [-2^(W_W-1), 2^(W_W-1)-1].
//  - OUT: out_valid=1; out_class, out_acc, out_upd stable until out_valid&out_ready.
//    The next cycle returns to IDLE.
//  - Latency, acceptance edge T to out_valid high:
//    - N+2 cycles with no update.
//    - 2N+3 cycles with an update.
//  - in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored.
//  - w_wr_en outside IDLE is ignored (weights are never changed mid-transaction).
//  - out_acc reports the pre-update sum. out_class is the pre-update decision.
//  - rst mid-transaction: immediate abort. All weights return to 0, out_valid drops.
//    No partial result is emitted.
// TESTING (N=4, IN_W=8, W_W=8, LR_SHIFT=0, BIAS_STEP=1)
//  1. Post-reset infer x={1,2,3,4} -> out_class=1, out_acc=0, out_upd=0, out_valid 6 cycles after accept.
//  2. Train x={10,0,0,0}, target=0 -> out_class=1, out_upd=1, w0=-10, bias=-1, latency 11.
//     Then infer the same x -> out_acc=-101, out_class=0.
//  3. Preload w0=-120, w1=127. Train x={100,100,0,0}, target=0 -> out_acc=700.
//     Afterwards w0=-128 (saturated), w1=27, bias=-1.
//  4. Hold out_ready=0 for 10 cycles in OUT -> out_valid, out_class, out_acc stable; in_ready=0.
//     Pulse in_valid -> not accepted.
//  5. Issue w_wr_en idx=0 data=55 during MAC -> w_rd_data(idx 0) unchanged.
//     Same write in IDLE -> reads 55 next cycle.
//  6. Assert rst during cycle 2 of MAC -> out_valid=0, in_ready=1 after release,
//     all w_rd_data=0, bias=0.

Source files
------------

// File: rtl/perceptron_trainable_if.sv
// Handshake, result and weight-access signals of the trainable perceptron.
// master drives features/strobes; slave is the perceptron core.
interface perceptron_trainable_if #(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned IN_W     = 8,
  parameter int unsigned W_W      = 8
);
  localparam int unsigned ACC_W = IN_W + W_W + $clog2(N_INPUTS) + 1;
  localparam int unsigned IDX_W = $clog2(N_INPUTS + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic [N_INPUTS*IN_W-1:0] in_data;
  logic                     train_en;
  logic                     target;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_class;
  logic [ACC_W-1:0]         out_acc;
  logic                     out_upd;
  logic                     w_wr_en;
  logic [IDX_W-1:0]         w_wr_idx;
  logic [W_W-1:0]           w_wr_data;
  logic [IDX_W-1:0]         w_rd_idx;
  logic [W_W-1:0]           w_rd_data;

  modport master (
    output in_valid, in_data, train_en, target, out_ready,
           w_wr_en, w_wr_idx, w_wr_data, w_rd_idx,
    input  in_ready, out_valid, out_class, out_acc, out_upd, w_rd_data
  );

  modport slave (
    input  in_valid, in_data, train_en, target, out_ready,
           w_wr_en, w_wr_idx, w_wr_data, w_rd_idx,
    output in_ready, out_valid, out_class, out_acc, out_upd, w_rd_data
  );
endinterface

// File: rtl/perceptron_trainable.sv
// Trainable perceptron: sequential MAC of dot(w,x)+bias, classification, and
// optional perceptron-rule update with saturating weights.
module perceptron_trainable #(
  parameter int unsigned N_INPUTS  = 4,
  parameter int unsigned IN_W      = 8,
  parameter int unsigned W_W       = 8,
  parameter int unsigned LR_SHIFT  = 0,
  parameter int unsigned BIAS_STEP = 1
) (
  input logic                   clk,
  input logic                   rst,
  perceptron_trainable_if.slave bus
);
  localparam int unsigned ACC_W  = IN_W + W_W + $clog2(N_INPUTS) + 1;
  localparam int unsigned IDX_W  = $clog2(N_INPUTS + 1);
  localparam int unsigned PROD_W = IN_W + W_W;
  localparam int unsigned SUM_W  = ((W_W > IN_W) ? W_W : IN_W) + 2;

  localparam logic signed [SUM_W-1:0] W_MAX = SUM_W'((2 ** (W_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] W_MIN = ~W_MAX;
  localparam logic signed [SUM_W-1:0] BSTEP = SUM_W'(BIAS_STEP);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DECIDE, S_UPDATE, S_OUT} state_t;

  function automatic logic signed [W_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
    if (v > W_MAX)      return W_W'(W_MAX);
    else if (v < W_MIN) return W_W'(W_MIN);
    else                return W_W'(v);
  endfunction

  state_t                  state_q, state_d;
  logic signed [W_W-1:0]   w_q [N_INPUTS];
  logic signed [W_W-1:0]   w_d [N_INPUTS];
  logic signed [IN_W-1:0]  x_q [N_INPUTS];
  logic signed [IN_W-1:0]  x_d [N_INPUTS];
  logic signed [W_W-1:0]   bias_q, bias_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    train_q, train_d, target_q, target_d;
  logic                    cls_q, cls_d, err_q, err_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_class_q, out_class_d;
  logic                    out_upd_q, out_upd_d;
  logic signed [ACC_W-1:0] out_acc_q, out_acc_d;

  logic signed [W_W-1:0]   sel_w;
  logic signed [IN_W-1:0]  sel_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0] upd_step, upd_sum, bias_sum;
  logic signed [W_W-1:0]   rd_data;
  logic                    cls_now;

  // Operand select for the current MAC/UPDATE index, plus the arithmetic on it.
  always_comb begin
    sel_w = '0;
    sel_x = '0;
    for (int i = 0; i < int'(N_INPUTS); i++) begin
      if (cnt_q == IDX_W'(i)) begin
        sel_w = w_q[i];
        sel_x = x_q[i];
      end
    end
    prod     = sel_w * sel_x;
    upd_step = SUM_W'(sel_x >>> LR_SHIFT);
    upd_sum  = target_q ? (SUM_W'(sel_w) + upd_step) : (SUM_W'(sel_w) - upd_step);
    bias_sum = target_q ? (SUM_W'(bias_q) + BSTEP) : (SUM_W'(bias_q) - BSTEP);
    cls_now  = ~acc_q[ACC_W-1];
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    x_d         = x_q;
    bias_d      = bias_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    train_d     = train_q;
    target_d    = target_q;
    cls_d       = cls_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_upd_d   = out_upd_q;
    out_acc_d   = out_acc_q;

    case (state_q)
      S_IDLE: begin
        // Preload lands before an acceptance in the same cycle.
        if (bus.w_wr_en) begin
          for (int i = 0; i < int'(N_INPUTS); i++) begin
            if (bus.w_wr_idx == IDX_W'(i)) w_d[i] = bus.w_wr_data;
          end
          if (bus.w_wr_idx == IDX_W'(N_INPUTS)) bias_d = bus.w_wr_data;
        end
        if (bus.in_valid) begin
          for (int i = 0; i < int'(N_INPUTS); i++) begin
            x_d[i] = bus.in_data[i*IN_W +: IN_W];
          end
          train_d    = bus.train_en;
          target_d   = bus.target;
          acc_d      = ACC_W'(bias_d);
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(N_INPUTS - 1)) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        cls_d   = cls_now;
        err_d   = train_q & (cls_now != target_q);
        cnt_d   = '0;
        state_d = (train_q & (cls_now != target_q)) ? S_UPDATE : S_OUT;
      end
      S_UPDATE: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(N_INPUTS)) begin
          bias_d  = saturate(bias_sum);
          state_d = S_OUT;
        end else begin
          for (int i = 0; i < int'(N_INPUTS); i++) begin
            if (cnt_q == IDX_W'(i)) w_d[i] = saturate(upd_sum);
          end
        end
      end
      S_OUT: begin
        // First OUT cycle captures the result; the handshake then returns to IDLE.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_class_d = cls_q;
          out_acc_d   = acc_q;
          out_upd_d   = err_q;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < int'(N_INPUTS); i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
      bias_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      train_q     <= 1'b0;
      target_q    <= 1'b0;
      cls_q       <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_class_q <= 1'b0;
      out_upd_q   <= 1'b0;
      out_acc_q   <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      x_q         <= x_d;
      bias_q      <= bias_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      train_q     <= train_d;
      target_q    <= target_d;
      cls_q       <= cls_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_upd_q   <= out_upd_d;
      out_acc_q   <= out_acc_d;
    end
  end

  // Combinational weight/bias readback; out-of-range index reads zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(N_INPUTS); i++) begin
      if (bus.w_rd_idx == IDX_W'(i)) rd_data = w_q[i];
    end
    if (bus.w_rd_idx == IDX_W'(N_INPUTS)) rd_data = bias_q;
  end

  assign bus.w_rd_data = rd_data;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_upd   = out_upd_q;
endmodule

// File: tb/tb_perceptron_trainable.sv
// Directed + randomized bench for perceptron_trainable against an integer model.
module tb_perceptron_trainable;
  localparam int unsigned N        = 4;
  localparam int unsigned IN_W     = 8;
  localparam int unsigned W_W      = 8;
  localparam int unsigned IDX_W    = $clog2(N + 1);
  localparam int          LR_SHIFT = 0;
  localparam int          BSTEP    = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  perceptron_trainable_if #(.N_INPUTS(N), .IN_W(IN_W), .W_W(W_W)) bif ();

  perceptron_trainable #(
    .N_INPUTS(N), .IN_W(IN_W), .W_W(W_W), .LR_SHIFT(LR_SHIFT), .BIAS_STEP(BSTEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int checks   = 0;
  int failures = 0;
  int mw[N];
  int mb;
  int tx[N];
  bit ttrain, ttarget;
  int obs_acc;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic rd_check(input string tag, input int idx, input int exp);
    bif.w_rd_idx = IDX_W'(idx);
    #1;
    check(tag, $signed(bif.w_rd_data), exp);
  endtask

  task automatic check_weights(input string tag);
    for (int i = 0; i <= int'(N); i++) rd_check(tag, i, (i < int'(N)) ? mw[i] : mb);
    rd_check({tag, "_oob"}, 7, 0);
  endtask

  task automatic preload(input int idx, input int val);
    @(negedge clk);
    bif.w_wr_en   = 1'b1;
    bif.w_wr_idx  = IDX_W'(idx);
    bif.w_wr_data = W_W'(val);
    @(posedge clk);
    @(negedge clk);
    bif.w_wr_en = 1'b0;
    if (idx < int'(N)) mw[idx] = val;
    else if (idx == int'(N)) mb = val;
    rd_check("preload_rd", idx, val);
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < int'(N); i++) bif.in_data[i*IN_W +: IN_W] = IN_W'(tx[i]);
    bif.train_en = ttrain;
    bif.target   = ttarget;
  endtask

  // One full transaction; the model decides acc, class, update and latency.
  task automatic txn(input string tag, input int hold, input bit mac_wr);
    int acc, n, explat;
    bit cls, err;
    acc = mb;
    for (int i = 0; i < int'(N); i++) acc += mw[i] * tx[i];
    cls    = (acc >= 0);
    err    = ttrain && (cls != ttarget);
    explat = err ? 2 * int'(N) + 3 : int'(N) + 2;

    @(negedge clk);
    check({tag, "_in_ready"}, bif.in_ready, 1);
    pack_inputs();
    bif.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
    if (mac_wr) begin
      bif.w_wr_en   = 1'b1;
      bif.w_wr_idx  = IDX_W'(0);
      bif.w_wr_data = W_W'(55);
    end
    n = 0;
    while (!bif.out_valid && n < 64) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1 && mac_wr) begin
        bif.w_wr_en = 1'b0;
        rd_check({tag, "_macwr_ignored"}, 0, mw[0]);
      end
    end
    check({tag, "_latency"}, n, explat);
    if (n >= 64) return;
    check({tag, "_out_valid"}, bif.out_valid, 1);
    check({tag, "_class"}, bif.out_class, cls);
    check({tag, "_acc"}, $signed(bif.out_acc), acc);
    check({tag, "_upd"}, bif.out_upd, err);
    obs_acc = int'($signed(bif.out_acc));

    for (int h = 0; h < hold; h++) begin
      bif.out_ready = 1'b0;
      if (h == 3) begin
        bif.in_valid = 1'b1;
        pack_inputs();
      end
      @(posedge clk);
      @(negedge clk);
      bif.in_valid = 1'b0;
      check({tag, "_hold_valid"}, bif.out_valid, 1);
      check({tag, "_hold_acc"}, $signed(bif.out_acc), acc);
      check({tag, "_hold_class"}, bif.out_class, cls);
      check({tag, "_hold_in_ready"}, bif.in_ready, 0);
    end

    bif.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.out_ready = 1'b0;
    check({tag, "_valid_drop"}, bif.out_valid, 0);
    check({tag, "_ready_back"}, bif.in_ready, 1);

    if (err) begin
      for (int i = 0; i < int'(N); i++)
        mw[i] = sat(ttarget ? mw[i] + (tx[i] >>> LR_SHIFT) : mw[i] - (tx[i] >>> LR_SHIFT));
      mb = sat(ttarget ? mb + BSTEP : mb - BSTEP);
    end
    check_weights({tag, "_w"});
  endtask

  task automatic set_x(input int a, input int b, input int c, input int d, input bit tr, input bit tg);
    tx[0] = a; tx[1] = b; tx[2] = c; tx[3] = d;
    ttrain = tr; ttarget = tg;
  endtask

  initial begin
    rst = 1'b1;
    bif.in_valid = 1'b0; bif.in_data = '0; bif.train_en = 1'b0; bif.target = 1'b0;
    bif.out_ready = 1'b0; bif.w_wr_en = 1'b0; bif.w_wr_idx = '0; bif.w_wr_data = '0;
    bif.w_rd_idx = '0;
    for (int i = 0; i < int'(N); i++) mw[i] = 0;
    mb = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", bif.in_ready, 1);
    check("rst_out_valid", bif.out_valid, 0);
    check("rst_out_class", bif.out_class, 0);
    check("rst_out_acc", $signed(bif.out_acc), 0);
    check("rst_out_upd", bif.out_upd, 0);
    check_weights("rst_w");

    set_x(1, 2, 3, 4, 1'b0, 1'b0);
    txn("t1", 0, 1'b0);
    check("t1_acc_const", obs_acc, 0);

    set_x(10, 0, 0, 0, 1'b1, 1'b0);
    txn("t2", 0, 1'b0);
    rd_check("t2_w0_const", 0, -10);
    rd_check("t2_bias_const", int'(N), -1);
    set_x(10, 0, 0, 0, 1'b0, 1'b0);
    txn("t2_infer", 0, 1'b0);
    check("t2_infer_acc_const", obs_acc, -101);

    preload(int'(N), 0);
    preload(0, -120);
    preload(1, 127);
    preload(2, 0);
    preload(3, 0);
    set_x(100, 100, 0, 0, 1'b1, 1'b0);
    txn("t3", 0, 1'b0);
    check("t3_acc_const", obs_acc, 700);
    rd_check("t3_w0_sat", 0, -128);
    rd_check("t3_w1", 1, 27);
    rd_check("t3_bias", int'(N), -1);

    set_x(-7, 33, 90, -128, 1'b0, 1'b0);
    txn("t4_hold", 10, 1'b0);

    set_x(5, -5, 12, 1, 1'b0, 1'b0);
    txn("t5_macwr", 0, 1'b1);
    preload(0, 55);

    // Reset during the second MAC cycle aborts and clears everything.
    set_x(3, 3, 3, 3, 1'b1, 1'b1);
    @(negedge clk);
    pack_inputs();
    bif.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_valid_in_rst", bif.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < int'(N); i++) mw[i] = 0;
    mb = 0;
    check("t6_in_ready", bif.in_ready, 1);
    check("t6_out_valid", bif.out_valid, 0);
    check_weights("t6_w");
    repeat (8) @(negedge clk);
    check("t6_no_late_result", bif.out_valid, 0);

    for (int t = 0; t < 24; t++) begin
      if (t % 6 == 5) preload(int'($urandom_range(0, N)), int'($urandom_range(0, 255)) - 128);
      for (int i = 0; i < int'(N); i++) tx[i] = int'($urandom_range(0, 255)) - 128;
      ttrain  = 1'($urandom_range(0, 1));
      ttarget = 1'($urandom_range(0, 1));
      txn("rand", int'($urandom_range(0, 2)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
